// File: rtl/result_streamer_if.sv
// Bundle between result_streamer, the result memory and the com bus.
// The slave side is the streamer itself.
interface result_streamer_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic                  process_done;
  logic [ADDR_WIDTH-1:0] out_base_addr;
  logic [ADDR_WIDTH-1:0] out_len;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic                  mem_rd_en;
  logic [DATA_WIDTH-1:0] mem_rdata;
  logic [DATA_WIDTH-1:0] com_data_out;
  logic                  output_write_start;
  logic                  output_write_done;
  logic                  busy;

  modport master (
    output process_done,
    output out_base_addr,
    output out_len,
    output mem_rdata,
    input  mem_addr,
    input  mem_rd_en,
    input  com_data_out,
    input  output_write_start,
    input  output_write_done,
    input  busy
  );

  modport slave (
    input  process_done,
    input  out_base_addr,
    input  out_len,
    input  mem_rdata,
    output mem_addr,
    output mem_rd_en,
    output com_data_out,
    output output_write_start,
    output output_write_done,
    output busy
  );
endinterface

// File: rtl/result_streamer.sv
// Reads a contiguous result region from memory and streams it onto
// com_data_out, one word per clock, framed by start/done strobes.
module result_streamer #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
) (
  input logic              clk,
  input logic              rst,
  result_streamer_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE,
    PRIME,
    STREAM,
    DONE
  } state_t;

  state_t                state_q, state_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic                  rd_q, rd_n;
  logic [ADDR_WIDTH-1:0] issued_q, issued_n;
  logic [ADDR_WIDTH-1:0] recv_q, recv_n;
  logic [ADDR_WIDTH-1:0] len_q, len_n;
  logic [DATA_WIDTH-1:0] data_q, data_n;
  logic                  start_q, start_n;
  logic                  done_q, done_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      rd_q     <= 1'b0;
      issued_q <= '0;
      recv_q   <= '0;
      len_q    <= '0;
      data_q   <= '0;
      start_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_n;
      addr_q   <= addr_n;
      rd_q     <= rd_n;
      issued_q <= issued_n;
      recv_q   <= recv_n;
      len_q    <= len_n;
      data_q   <= data_n;
      start_q  <= start_n;
      done_q   <= done_n;
    end
  end

  always_comb begin
    state_n  = state_q;
    addr_n   = addr_q;
    rd_n     = rd_q;
    issued_n = issued_q;
    recv_n   = recv_q;
    len_n    = len_q;
    data_n   = data_q;
    start_n  = 1'b0;
    done_n   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.process_done) begin
          len_n    = bus.out_len;
          issued_n = '0;
          recv_n   = '0;
          if (bus.out_len == '0) begin
            done_n  = 1'b1;
            state_n = DONE;
          end else begin
            addr_n   = bus.out_base_addr;
            rd_n     = 1'b1;
            issued_n = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            state_n  = PRIME;
          end
        end
      end
      PRIME: begin
        if (issued_q != len_q) begin
          addr_n   = addr_q + 1'b1;
          issued_n = issued_q + 1'b1;
        end else begin
          rd_n = 1'b0;
        end
        state_n = STREAM;
      end
      STREAM: begin
        // Read issue runs one word ahead of capture.
        if (recv_q == len_q) begin
          rd_n    = 1'b0;
          state_n = DONE;
        end else begin
          if (issued_q != len_q) begin
            addr_n   = addr_q + 1'b1;
            issued_n = issued_q + 1'b1;
          end else begin
            rd_n = 1'b0;
          end
          data_n  = bus.mem_rdata;
          start_n = 1'b1;
          recv_n  = recv_q + 1'b1;
          done_n  = ((recv_q + 1'b1) == len_q);
        end
      end
      DONE: begin
        rd_n = 1'b0;
        if (!bus.process_done) state_n = IDLE;
      end
    endcase
  end

  assign bus.mem_addr           = addr_q;
  assign bus.mem_rd_en          = rd_q;
  assign bus.com_data_out       = data_q;
  assign bus.output_write_start = start_q;
  assign bus.output_write_done  = done_q;
  assign bus.busy = (state_q == PRIME) || (state_q == STREAM);
endmodule

// File: tb/tb_result_streamer.sv
// Randomised bench for result_streamer with a memory model and a
// reference stream computed from base/len arithmetic.
module tb_result_streamer;
  localparam int DW = 16;
  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  result_streamer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  result_streamer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (bus.mem_rd_en) bus.mem_rdata <= mem[bus.mem_addr];

  int n_chk = 0;
  int n_fail = 0;

  logic [DW-1:0] got[$];
  logic [DW-1:0] prev[$];
  logic [AW-1:0] addrs[$];
  int first_cyc, done_cyc, done_cnt, rd_cnt, gap, last_s;

  function automatic logic [DW-1:0] model(input logic [AW-1:0] base, input int i);
    logic [AW-1:0] a;
    a = base + AW'(i);
    return mem[a];
  endfunction

  // Raise process_done just after a negedge and record what the bus does.
  task automatic collect(input logic [AW-1:0] base, input logic [AW-1:0] len,
                         input bit scramble, input int budget);
    got.delete();
    addrs.delete();
    first_cyc = -1; done_cyc = -1; done_cnt = 0;
    rd_cnt = 0; gap = 0; last_s = -1;
    bus.out_base_addr = base;
    bus.out_len = len;
    bus.process_done = 1'b1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk);
      if (scramble) begin
        bus.out_base_addr = AW'($urandom);
        bus.out_len = AW'($urandom);
      end
      if (bus.mem_rd_en) begin
        rd_cnt++;
        addrs.push_back(bus.mem_addr);
      end
      if (bus.output_write_start) begin
        if (first_cyc < 0) first_cyc = c;
        else if (c != last_s + 1) gap++;
        last_s = c;
        got.push_back(bus.com_data_out);
      end
      if (bus.output_write_done) begin
        done_cnt++;
        done_cyc = c;
      end
    end
  endtask

  task automatic release_pd();
    bus.process_done = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.mem_addr, bus.mem_rd_en, bus.com_data_out, bus.output_write_start,
         bus.output_write_done, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got addr=%h rd=%b data=%h s=%b d=%b busy=%b, want all 0",
               bus.mem_addr, bus.mem_rd_en, bus.com_data_out,
               bus.output_write_start, bus.output_write_done, bus.busy);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_chk++;
      if ({bus.mem_rd_en, bus.busy, bus.output_write_start} !== 3'b000) begin
        n_fail++;
        $display("FAIL idle_quiet: got rd=%b busy=%b s=%b, want 0", bus.mem_rd_en,
                 bus.busy, bus.output_write_start);
      end
    end
  endtask

  task automatic test_basic();
    mem[12'h010] = 16'h0001; mem[12'h011] = 16'h0004;
    mem[12'h012] = 16'h0007; mem[12'h013] = 16'h000A;
    collect(12'h010, 12'd4, 1'b0, 10);
    n_chk++;
    if (got.size() != 4) begin
      n_fail++;
      $display("FAIL basic_count: got %0d words, want 4", got.size());
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      n_chk++;
      if (got[i] !== model(12'h010, i)) begin
        n_fail++;
        $display("FAIL basic_word%0d: got %h want %h", i, got[i], model(12'h010, i));
      end
    end
    n_chk++;
    if (first_cyc != 3 || gap != 0 || done_cnt != 1 || done_cyc != 6) begin
      n_fail++;
      $display("FAIL basic_timing: got first=%0d gap=%0d dcnt=%0d dcyc=%0d, want 3 0 1 6",
               first_cyc, gap, done_cnt, done_cyc);
    end
    n_chk++;
    if (bus.com_data_out !== 16'h000A || bus.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_hold: got data=%h busy=%b, want 000a 0", bus.com_data_out, bus.busy);
    end
    release_pd();
  endtask

  task automatic test_single();
    mem[12'h020] = 16'hBEEF;
    collect(12'h020, 12'd1, 1'b0, 7);
    n_chk++;
    if (got.size() != 1 || first_cyc != 3 || done_cyc != 3 || done_cnt != 1 || rd_cnt != 1) begin
      n_fail++;
      $display("FAIL single_frame: got n=%0d first=%0d dcyc=%0d dcnt=%0d rd=%0d, want 1 3 3 1 1",
               got.size(), first_cyc, done_cyc, done_cnt, rd_cnt);
    end
    n_chk++;
    if (got.size() != 1 || got[0] !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL single_word: got %h want beef", got.size() ? got[0] : 16'hxxxx);
    end
    release_pd();
  endtask

  task automatic test_zero();
    collect(12'h100, 12'd0, 1'b0, 8);
    n_chk++;
    if (got.size() != 0 || rd_cnt != 0 || done_cnt != 1 || done_cyc != 1) begin
      n_fail++;
      $display("FAIL zero_len: got n=%0d rd=%0d dcnt=%0d dcyc=%0d, want 0 0 1 1",
               got.size(), rd_cnt, done_cnt, done_cyc);
    end
    release_pd();
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 4; i++) mem[12'hFFE + 12'(i)] = DW'($urandom);
    collect(12'hFFE, 12'd4, 1'b1, 10);
    n_chk++;
    if (addrs.size() != 4 || addrs[0] !== 12'hFFE || addrs[1] !== 12'hFFF ||
        addrs[2] !== 12'h000 || addrs[3] !== 12'h001) begin
      n_fail++;
      $display("FAIL wrap_addr: got %0d addrs, want ffe fff 000 001", addrs.size());
    end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (i >= got.size() || got[i] !== model(12'hFFE, i)) begin
        n_fail++;
        $display("FAIL wrap_word%0d: want %h", i, model(12'hFFE, i));
      end
    end
    n_chk++;
    if (done_cyc != 6 || done_cnt != 1) begin
      n_fail++;
      $display("FAIL wrap_done: got dcyc=%0d dcnt=%0d, want 6 1", done_cyc, done_cnt);
    end
    release_pd();
  endtask

  task automatic test_random();
    for (int t = 0; t < 12; t++) begin
      logic [AW-1:0] b, l;
      int err;
      b = AW'($urandom);
      l = AW'($urandom_range(1, 40));
      collect(b, l, 1'b1, int'(l) + 6);
      err = 0;
      for (int i = 0; i < int'(l); i++)
        if (i >= got.size() || got[i] !== model(b, i)) err++;
      n_chk++;
      if (err != 0 || got.size() != int'(l)) begin
        n_fail++;
        $display("FAIL rand%0d_data: got n=%0d bad=%0d, want n=%0d", t, got.size(), err, l);
      end
      n_chk++;
      if (first_cyc != 3 || gap != 0 || done_cnt != 1 || done_cyc != int'(l) + 2 ||
          rd_cnt != int'(l)) begin
        n_fail++;
        $display("FAIL rand%0d_frame: got first=%0d gap=%0d dcnt=%0d dcyc=%0d rd=%0d, want len=%0d",
                 t, first_cyc, gap, done_cnt, done_cyc, rd_cnt, l);
      end
      release_pd();
    end
  endtask

  task automatic test_reset_midstream();
    int words, dn;
    for (int i = 0; i < 8; i++) mem[i] = DW'($urandom);
    bus.out_base_addr = '0;
    bus.out_len = 12'd8;
    bus.process_done = 1'b1;
    words = 0;
    dn = 0;
    for (int c = 0; c < 20 && words < 3; c++) begin
      @(negedge clk);
      if (bus.output_write_start) words++;
      if (bus.output_write_done) dn++;
    end
    n_chk++;
    if (words != 3 || dn != 0) begin
      n_fail++;
      $display("FAIL mid_pre: got words=%0d done=%0d, want 3 0", words, dn);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if ({bus.mem_addr, bus.mem_rd_en, bus.com_data_out, bus.output_write_start,
         bus.output_write_done, bus.busy} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: got rd=%b s=%b d=%b busy=%b data=%h, want all 0",
               bus.mem_rd_en, bus.output_write_start, bus.output_write_done,
               bus.busy, bus.com_data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    collect('0, 12'd8, 1'b0, 14);
    prev = got;
    n_chk++;
    if (got.size() != 8 || first_cyc != 3 || done_cnt != 1 || done_cyc != 10) begin
      n_fail++;
      $display("FAIL mid_restart: got n=%0d first=%0d dcnt=%0d dcyc=%0d, want 8 3 1 10",
               got.size(), first_cyc, done_cnt, done_cyc);
    end
    for (int i = 0; i < 8; i++) begin
      n_chk++;
      if (i >= got.size() || got[i] !== model('0, i)) begin
        n_fail++;
        $display("FAIL mid_word%0d: want %h", i, model('0, i));
      end
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    extra = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.output_write_start || bus.mem_rd_en || bus.output_write_done) extra++;
    end
    n_chk++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL b2b_hold: got %0d active cycles, want 0", extra);
    end
    release_pd();
    collect('0, 12'd8, 1'b0, 14);
    n_chk++;
    if (got != prev || done_cnt != 1 || first_cyc != 3) begin
      n_fail++;
      $display("FAIL b2b_second: got n=%0d dcnt=%0d first=%0d, want repeat of 8 words",
               got.size(), done_cnt, first_cyc);
    end
    release_pd();
  endtask

  initial begin
    bus.process_done = 1'b0;
    bus.out_base_addr = '0;
    bus.out_len = '0;
    bus.mem_rdata = '0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    test_reset();
    test_basic();
    test_single();
    test_zero();
    test_wrap();
    test_random();
    test_reset_midstream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/result_streamer.md
Name: result_streamer

Overview:
- Output stage of the multi-core processor top level. Sits between the shared result memory and the external com_data_out bus.
- Once the cores signal completion, it reads a contiguous result region from memory, one word per clock, and streams it out.
- Framing uses output_write_start / output_write_done. The external host samples com_data_out on every posedge while output_write_start=1, and stops on the edge where output_write_done=1.

Parameters:
- DATA_WIDTH, 16, width of memory words and com_data_out.
- ADDR_WIDTH, 12, memory address width; also the width of the length field.

Ports:
- clk  input  1  system clock; all logic on posedge.
- rst  input  1  asynchronous, active-high reset.
- process_done  input  1  level from the core controller; high when all cores have finished writing results.
- out_base_addr  input  ADDR_WIDTH  first result address; latched on start.
- out_len  input  ADDR_WIDTH  number of words to stream; latched on start.
- mem_addr  output  ADDR_WIDTH  result memory read address.
- mem_rd_en  output  1  result memory read enable.
- mem_rdata  input  DATA_WIDTH  read data, valid the cycle after mem_addr/mem_rd_en are sampled (1-cycle synchronous read).
- com_data_out  output  DATA_WIDTH  streamed word (registered).
- output_write_start  output  1  high exactly in cycles where com_data_out holds a valid word.
- output_write_done  output  1  one-cycle pulse marking the end of the stream.
- busy  output  1  high in PRIME and STREAM.

Behaviour:
- Reset (async, any state):
  - State returns to IDLE.
  - All outputs go to 0: mem_addr, mem_rd_en, com_data_out, output_write_start, output_write_done, busy.
  - Internal counters clear.
- States: IDLE, PRIME, STREAM, DONE.
- IDLE:
  - On the edge sampling process_done=1, latch base=out_base_addr and len=out_len.
  - If len=0: pulse output_write_done for one cycle with output_write_start=0, then go to DONE.
  - Otherwise: drive mem_addr=base and mem_rd_en=1, then go to PRIME.
- PRIME:
  - Covers the memory read latency.
  - Advance mem_addr by 1 each cycle while reads remain. mem_rd_en drops after the len-th address has been issued.
- STREAM:
  - com_data_out <= mem_rdata and output_write_start=1, one word per cycle with no gaps.
  - Words appear in address order: base, base+1, … base+len-1.
- Latency: the first word is valid, with output_write_start=1, in the cycle after the 3rd posedge counting the edge that sampled process_done=1.
- End of stream:
  - output_write_done=1 in the same cycle as the last word, i.e. simultaneously with output_write_start=1.
  - For len=1, start and done are high together in a single cycle.
  - Next cycle: output_write_start=0, output_write_done=0, go to DONE.
- DONE:
  - Outputs idle; com_data_out holds the last word.
  - Stays in DONE while process_done=1. Returns to IDLE when process_done=0, so exactly one stream per process_done assertion (re-arm requires deassertion).
- Address arithmetic is modulo 2^ADDR_WIDTH: base+len past the top wraps to 0.
- Word counter is ADDR_WIDTH bits; max len = 2^ADDR_WIDTH-1.
- Changes to out_base_addr / out_len after the start edge are ignored until the next IDLE start.
- process_done falling during PRIME/STREAM is ignored; the stream completes.
- Reset mid-stream: the stream is abandoned immediately with no resumption. A fresh process_done restarts from the new latched base.
- No backpressure: the consumer must accept one word per cycle.

Test Plan:
- Reset: assert rst asynchronously between edges -> all outputs 0 immediately; state IDLE; no memory reads while process_done=0.
- Basic stream: mem[0x010..0x013]=0x0001,0x0004,0x0007,0x000A; base=0x010, len=4; raise process_done -> exact 4-word sequence. output_write_start high for 4 consecutive cycles starting the cycle after the 3rd edge. output_write_done high only with 0x000A.
- Single word: base=0x020, len=1, mem[0x020]=0xBEEF -> one cycle with com_data_out=0xBEEF, output_write_start=1 and output_write_done=1 together.
- Zero length: len=0 -> output_write_done pulses once; output_write_start never rises; mem_rd_en never asserted.
- Wrap: ADDR_WIDTH=4, base=14, len=4 -> mem_addr sequence 14,15,0,1; data in that order; done with the 4th word.
- Reset mid-stream plus re-arm:
  - base=0, len=8; assert rst after 3 words -> outputs 0 at once, no done pulse.
  - Release rst with process_done still high -> restart from address 0; all 8 words delivered.
  - Hold process_done high after done -> no second stream. Drop then raise process_done -> second identical stream.
